i_serdes_rx: RTL and testbench

- Input deserializer that shifts serial data D in on the fast bit clock PLL_CLK and emits WIDTH-bit parallel words Q, one per word period.
- Provides a generated word-rate clock CLK_OUT, a data-valid flag and a user bit-slip for word alignment.
- Sits between a high-speed I/O pad and fabric logic running on a word-rate core clock (CLK_IN).

---
 rtl/i_serdes_rx.sv | 126 ++++++++++++
 tb/tb_i_serdes_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_serdes_rx.sv
// i_serdes_rx: SDR/DDR input deserializer with user bit-slip,
// divided word clock and data-valid tracking.
module i_serdes_rx #(
  parameter string DATA_RATE = "SDR",
  parameter int    WIDTH     = 4,
  parameter string DPA_MODE  = "NONE"
) (
  input  logic             PLL_CLK,
  input  logic             RX_RST,
  input  logic             D,
  input  logic             EN,
  input  logic             BITSLIP_ADJ,
  input  logic             CLK_IN,
  input  logic             PLL_LOCK,
  output logic             CLK_OUT,
  output logic [WIDTH-1:0] Q,
  output logic             DATA_VALID,
  output logic             DPA_LOCK,
  output logic             DPA_ERROR
);

  localparam int B  = (DATA_RATE == "DDR") ? 2 : 1;
  localparam int P  = WIDTH / B;
  localparam int H  = (P + 1) / 2;
  localparam int HW = 2 * WIDTH;
  localparam int CW = $clog2(P + 1);
  localparam int SW = $clog2(WIDTH);
  localparam int BW = $clog2(HW);
  localparam bit DPA_ON = (DPA_MODE != "NONE");

  logic [HW-1:0]    r_hist;
  logic [CW-1:0]    r_wcnt;
  logic [CW-1:0]    r_ccnt;
  logic [SW-1:0]    r_slip;
  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_clk_out;
  logic             r_dpa_lock;

  logic [HW-1:0]    w_hist_sh;
  logic [BW-1:0]    w_base;
  logic [WIDTH-1:0] w_win;
  logic             w_run;
  logic             w_cap;
  logic             w_slip_edge;
  logic             w_unused;

  generate
    if (B == 2) begin : g_ddr
      logic r_fall;
      // hold the early bit of each pair, sampled on the falling edge
      always_ff @(negedge PLL_CLK) begin
        r_fall <= D;
      end
      assign w_hist_sh = {D, r_fall, r_hist[HW-1:2]};
    end else begin : g_sdr
      assign w_hist_sh = {D, r_hist[HW-1:1]};
    end
  endgenerate

  assign w_run       = EN & PLL_LOCK;
  assign w_cap       = w_run && (r_wcnt == CW'(P - 1));
  assign w_base      = BW'(WIDTH) - BW'(r_slip);
  assign w_win       = WIDTH'(w_hist_sh >> w_base);
  assign w_slip_edge = r_sync[1] & ~r_sync_d;
  assign w_unused    = ^{CLK_IN, r_hist[1:0]};

  // shift in bits, count word period, capture slipped window
  always_ff @(posedge PLL_CLK) begin
    if (!RX_RST) begin
      r_hist  <= '0;
      r_wcnt  <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      if (EN) r_hist <= w_hist_sh;
      if (w_run) begin
        r_wcnt <= (r_wcnt == CW'(P - 1)) ? '0 : r_wcnt + CW'(1);
      end
      if (w_cap) r_q <= w_win;
      if (!w_run) r_valid <= 1'b0;
      else if (w_cap) r_valid <= 1'b1;
    end
  end

  // synchronize slip request and bump offset once per rising edge
  always_ff @(posedge PLL_CLK) begin
    if (!RX_RST) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_slip   <= '0;
    end else begin
      r_sync   <= {r_sync[0], BITSLIP_ADJ};
      r_sync_d <= r_sync[1];
      if (w_slip_edge) begin
        r_slip <= (r_slip == SW'(WIDTH - 1)) ? '0 : r_slip + SW'(1);
      end
    end
  end

  // free-running word clock, high for the first half of each period
  always_ff @(posedge PLL_CLK) begin
    if (!RX_RST || !PLL_LOCK) begin
      r_ccnt    <= '0;
      r_clk_out <= 1'b0;
    end else begin
      r_ccnt    <= (r_ccnt == CW'(P - 1)) ? '0 : r_ccnt + CW'(1);
      r_clk_out <= (r_ccnt < CW'(H));
    end
  end

  // phase-alignment lock follows the active receive condition
  always_ff @(posedge PLL_CLK) begin
    if (!RX_RST) r_dpa_lock <= 1'b0;
    else         r_dpa_lock <= DPA_ON & w_run;
  end

  assign Q          = r_q;
  assign DATA_VALID = r_valid;
  assign CLK_OUT    = r_clk_out;
  assign DPA_LOCK   = r_dpa_lock;
  assign DPA_ERROR  = 1'b0;

endmodule

// File: tb/tb_i_serdes_rx.sv
// tb_i_serdes_rx: SDR and DDR deserializer instances checked
// against a bit-stream reference model.
module tb_i_serdes_rx;

  logic       clk = 1'b0;
  logic       rst_n, en, lk, ds, d_ddr, slp;
  logic       slp_d = 1'b0;
  logic       cin = 1'b0;
  logic       clk_s, v_s, dpa_s, err_s;
  logic       clk_d, v_d, dpa_d, err_d;
  logic [3:0] q_s, q_d;

  always #5 clk = ~clk;

  i_serdes_rx #(.DATA_RATE("SDR"), .WIDTH(4), .DPA_MODE("DPA")) u_sdr (
    .PLL_CLK(clk), .RX_RST(rst_n), .D(ds), .EN(en),
    .BITSLIP_ADJ(slp), .CLK_IN(cin), .PLL_LOCK(lk),
    .CLK_OUT(clk_s), .Q(q_s), .DATA_VALID(v_s),
    .DPA_LOCK(dpa_s), .DPA_ERROR(err_s)
  );

  i_serdes_rx #(.DATA_RATE("DDR"), .WIDTH(4), .DPA_MODE("NONE")) u_ddr (
    .PLL_CLK(clk), .RX_RST(rst_n), .D(d_ddr), .EN(en),
    .BITSLIP_ADJ(slp_d), .CLK_IN(cin), .PLL_LOCK(lk),
    .CLK_OUT(clk_d), .Q(q_d), .DATA_VALID(v_d),
    .DPA_LOCK(dpa_d), .DPA_ERROR(err_d)
  );

  int total = 0;
  int bad   = 0;

  bit         qs[$];
  bit         qd[$];
  int         ns, nd, lc, si, slip;
  bit         vs, vd, eclk_s, eclk_d, edpa;
  logic [3:0] exs, exd, pat;
  bit         busy, qsync, rnd;
  bit         df, dr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] win(input bit q[$], input int s);
    int len;
    len = q.size();
    win = '0;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = len - 4 - s + i;
      win[i] = (idx >= 0) ? q[idx] : 1'b0;
    end
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      qs.delete(); qd.delete();
      ns = 0; nd = 0; lc = 0; si = 0; slip = 0;
      vs = 0; vd = 0; exs = '0; exd = '0;
      eclk_s = 0; eclk_d = 0; edpa = 0; qsync = 1;
    end else begin
      edpa = en & lk;
      if (lk) begin
        eclk_s = (lc % 4) < 2;
        eclk_d = (lc % 2) < 1;
        lc++;
      end else begin
        lc = 0; eclk_s = 0; eclk_d = 0;
      end
      if (en) begin
        qs.push_back(ds);
        qd.push_back(df);
        qd.push_back(dr);
        si++;
        while (qs.size() > 32) void'(qs.pop_front());
        while (qd.size() > 32) void'(qd.pop_front());
      end
      if (en && lk) begin
        ns++; nd++;
        if (ns % 4 == 0) begin
          vs = 1; exs = win(qs, slip);
          if (!busy) qsync = 1;
        end
        if (nd % 2 == 0) begin
          vd = 1; exd = win(qd, 0);
        end
      end else begin
        vs = 0; vd = 0;
      end
    end
  endtask

  task automatic tick();
    if (rnd) begin
      ds = 1'($urandom % 2);
      df = 1'($urandom % 2);
      dr = 1'($urandom % 2);
    end else begin
      ds = pat[si % 4];
      df = 1'b1;
      dr = 1'b0;
    end
    d_ddr = df;
    @(negedge clk);
    #1 d_ddr = dr;
    @(posedge clk);
    model_edge();
    #1;
    if (qsync) chk("s_q", q_s, exs);
    chk("s_valid", v_s, vs);
    chk("s_clkout", clk_s, eclk_s);
    chk("s_dpalock", dpa_s, edpa);
    chk("s_dpaerr", err_s, 0);
    chk("d_q", q_d, exd);
    chk("d_valid", v_d, vd);
    chk("d_clkout", clk_d, eclk_d);
    chk("d_dpalock", dpa_d, 0);
    chk("d_dpaerr", err_d, 0);
  endtask

  task automatic slip_pulse();
    busy = 1; qsync = 0; slp = 1;
    repeat (8) tick();
    slp = 0;
    slip = (slip + 1) % 4;
    repeat (2) tick();
    busy = 0;
  endtask

  initial begin
    rst_n = 0; en = 1; lk = 1; ds = 0; d_ddr = 0; slp = 0;
    busy = 0; qsync = 1; rnd = 0; pat = 4'b0101;
    ns = 0; nd = 0; lc = 0; si = 0; slip = 0;
    @(posedge clk);
    #1;
    repeat (2) tick();
    chk("rst_q", q_s, 0);
    chk("rst_valid", v_s, 0);
    chk("rst_clkout", clk_s, 0);
    chk("rst_dpalock", dpa_s, 0);

    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 1) chk("ddr_first_q", q_d, 4'h5);
      if (i == 2) chk("first_valid_lo", v_s, 0);
      if (i == 3) begin
        chk("first_q", q_s, 4'h5);
        chk("first_valid", v_s, 1);
      end
    end

    for (int p = 0; p < 3; p++) begin
      logic [3:0] want;
      want = (p % 2 == 0) ? 4'hA : 4'h5;
      slip_pulse();
      repeat (6) tick();
      chk("slip_q", q_s, want);
    end

    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    pat = 4'b1011;
    repeat (4) tick();
    chk("align_q", q_s, 4'hB);
    for (int p = 0; p < 4; p++) begin
      slip_pulse();
      repeat (6) tick();
    end
    chk("wrap_q", q_s, 4'hB);

    repeat (2) tick();
    begin
      logic [3:0] held;
      held = exs;
      en = 0;
      tick();
      chk("en_drop_valid", v_s, 0);
      chk("en_drop_q", q_s, held);
      repeat (4) tick();
      chk("en_hold_q", q_s, held);
    end
    en = 1;
    tick();
    chk("reen_valid_lo", v_s, 0);
    tick();
    chk("reen_valid", v_s, 1);

    lk = 0;
    tick();
    chk("lock_clkout", clk_s, 0);
    chk("lock_valid", v_s, 0);
    repeat (5) tick();
    chk("lock_ddr_clkout", clk_d, 0);
    lk = 1;
    repeat (8) tick();

    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 40 == 0) begin
        rst_n = 1; en = 1; lk = 1;
        slip_pulse();
      end else begin
        rst_n = ($urandom % 64) != 0;
        en    = ($urandom % 10) != 0;
        lk    = ($urandom % 16) != 0;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
